// File: rtl/core_mem_bridge.sv
// Byte-bus responder that maps core accesses onto a 16-bit async SRAM with wait states.
// Latency: a buffer hit costs 0 cycles, a read miss WAIT+2 stall cycles, a write WAIT+1 stall cycles after capture.
// Backpressure: locked=0 stalls the core; a write is taken on the IDLE edge and the core is then held while it drains.
module core_mem_bridge #(
  parameter int WAIT = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic        we,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        locked,
  output logic [14:0] sram_a,
  input  logic [15:0] sram_d_i,
  output logic [15:0] sram_d_o,
  output logic        sram_d_oe,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [14:0] tag;
  logic        valid;
  logic [15:0] rd_buf;
  logic [14:0] rd_addr;
  logic [15:0] waddr;
  logic [7:0]  wdata;
  logic        hit;

  assign hit  = valid && (address[15:1] == tag);
  assign dout = address[0] ? rd_buf[15:8] : rd_buf[7:0];

  // State register; a reset mid-access drops straight back to IDLE, which releases every strobe.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, core stall and SRAM pin decode; the pins follow the registered state so they never glitch on address changes.
  always_comb begin
    state_nxt = state;
    locked    = 1'b0;
    sram_a    = rd_addr;
    sram_d_o  = {wdata, wdata};
    sram_d_oe = 1'b0;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    sram_ub_n = 1'b1;
    sram_lb_n = 1'b1;
    unique case (state)
      IDLE: begin
        locked = we | hit;
        if (we) begin
          state_nxt = WRITE;
        end else if (!hit) begin
          state_nxt = READ;
        end
      end
      READ: begin
        sram_oe_n = 1'b0;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
        if (cnt == 4'd0) begin
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        sram_a    = waddr[15:1];
        sram_d_oe = 1'b1;
        sram_we_n = 1'b0;
        sram_ub_n = ~waddr[0];
        sram_lb_n = waddr[0];
        if (cnt == 4'd0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // The core must see its own reset, so it is never stalled while reset is held.
    if (!reset_n) begin
      locked = 1'b1;
    end
  end

  // Datapath: write capture with write-through into the buffer, miss address latch, wait counting and buffer fill.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt     <= 4'd0;
      tag     <= 15'd0;
      valid   <= 1'b0;
      rd_buf  <= 16'd0;
      rd_addr <= 15'd0;
      waddr   <= 16'd0;
      wdata   <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (we) begin
            waddr <= address;
            wdata <= din;
            cnt   <= WAIT_CNT;
            if (hit) begin
              if (address[0]) begin
                rd_buf[15:8] <= din;
              end else begin
                rd_buf[7:0] <= din;
              end
            end
          end else if (!hit) begin
            rd_addr <= address[15:1];
            cnt     <= WAIT_CNT;
          end
        end
        READ: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rd_buf <= sram_d_i;
            tag    <= rd_addr;
            valid  <= 1'b1;
          end
        end
        WRITE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_bridge.sv
// Directed bench for core_mem_bridge: a WAIT=2 instance on a modelled SRAM and a WAIT=0 instance on a fixed word.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point, away from the edge.
// Expected values are hand-computed constants from the bus protocol.
module tb_core_mem_bridge;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] address;
  logic        we;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        locked;
  logic [14:0] sram_a;
  logic [15:0] sram_d_i;
  logic [15:0] sram_d_o;
  logic        sram_d_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  logic        reset_n_w0;
  logic [15:0] address_w0;
  logic        we_w0;
  logic [7:0]  din_w0;
  logic [7:0]  dout_w0;
  logic        locked_w0;
  logic [14:0] sram_a_w0;
  logic [15:0] sram_d_i_w0;
  logic [15:0] sram_d_o_w0;
  logic        sram_d_oe_w0, sram_oe_n_w0, sram_we_n_w0, sram_ub_n_w0, sram_lb_n_w0;

  logic [15:0] mem [0:32767];
  logic        pl_req = 1'b0;
  logic [14:0] pl_addr = 15'd0;
  logic [15:0] pl_dat = 16'd0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  core_mem_bridge #(.WAIT(2)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .we(we), .din(din),
    .dout(dout), .locked(locked), .sram_a(sram_a), .sram_d_i(sram_d_i),
    .sram_d_o(sram_d_o), .sram_d_oe(sram_d_oe), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  core_mem_bridge #(.WAIT(0)) dut_w0 (
    .clock(clock), .reset_n(reset_n_w0), .address(address_w0), .we(we_w0), .din(din_w0),
    .dout(dout_w0), .locked(locked_w0), .sram_a(sram_a_w0), .sram_d_i(sram_d_i_w0),
    .sram_d_o(sram_d_o_w0), .sram_d_oe(sram_d_oe_w0), .sram_oe_n(sram_oe_n_w0),
    .sram_we_n(sram_we_n_w0), .sram_ub_n(sram_ub_n_w0), .sram_lb_n(sram_lb_n_w0)
  );

  // SRAM model: asynchronous read, byte-lane writes while we_n is low, plus a bench preload port.
  assign sram_d_i = mem[sram_a];
  always @(posedge clock) begin
    if (pl_req) begin
      mem[pl_addr] <= pl_dat;
    end else if (!sram_we_n) begin
      if (!sram_lb_n) mem[sram_a][7:0]  <= sram_d_o[7:0];
      if (!sram_ub_n) mem[sram_a][15:8] <= sram_d_o[15:8];
    end
  end

  assign sram_d_i_w0 = (sram_a_w0 == 15'h7FFF) ? 16'h9900 : 16'h0000;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [14:0] a, input logic [15:0] d);
    pl_req  = 1'b1;
    pl_addr = a;
    pl_dat  = d;
    tick();
    pl_req  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; we = 1'b0; din = 8'h00; address = 16'h0000;
    reset_n_w0 = 1'b0; we_w0 = 1'b0; din_w0 = 8'h00; address_w0 = 16'hFFFF;
    tick();
    preload(15'h0000, 16'h31C0);
    preload(15'h0080, 16'h0000);
    preload(15'h1000, 16'h0000);
    tick();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL reset_locked got %b exp 1", locked); end
    checks++; if ({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 4'hF) begin errors++;
      $display("FAIL reset_strobes got %h exp f", {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}); end
    checks++; if (sram_d_oe !== 1'b0) begin errors++; $display("FAIL reset_d_oe got %b exp 0", sram_d_oe); end
    checks++; if (sram_a !== 15'h0000) begin errors++; $display("FAIL reset_sram_a got %h exp 0000", sram_a); end
    checks++; if (sram_d_o !== 16'h0000) begin errors++; $display("FAIL reset_sram_d_o got %h exp 0000", sram_d_o); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
  endtask

  task automatic test_read_miss();
    int n;
    reset_n = 1'b1; address = 16'h0000;
    #1;
    n = 0;
    while (!locked && n < 20) begin
      if (n > 0) begin
        checks++; if ({sram_oe_n, sram_d_oe, sram_ub_n, sram_lb_n} !== 4'b0000) begin errors++;
          $display("FAIL miss_read_pins cycle %0d got %b exp 0000", n, {sram_oe_n, sram_d_oe, sram_ub_n, sram_lb_n}); end
      end
      n++;
      tick();
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL miss_stall_cycles got %0d exp 4", n); end
    checks++; if (dout !== 8'hC0) begin errors++; $display("FAIL miss_dout_lo got %h exp c0", dout); end
    address = 16'h0001;
    #1;
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL hit_odd_locked got %b exp 1", locked); end
    checks++; if (dout !== 8'h31) begin errors++; $display("FAIL hit_odd_dout got %h exp 31", dout); end
  endtask

  task automatic test_write();
    int n;
    address = 16'h0101; din = 8'hAA; we = 1'b1;
    #1;
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL wr_capture_locked got %b exp 1", locked); end
    tick();
    n = 0;
    while (!locked && n < 20) begin
      checks++; if (sram_a !== 15'h0080) begin errors++; $display("FAIL wr_sram_a got %h exp 0080", sram_a); end
      checks++; if ({sram_we_n, sram_ub_n, sram_lb_n, sram_oe_n, sram_d_oe} !== 5'b00111) begin errors++;
        $display("FAIL wr_strobes got %b exp 00111", {sram_we_n, sram_ub_n, sram_lb_n, sram_oe_n, sram_d_oe}); end
      checks++; if (sram_d_o !== 16'hAAAA) begin errors++; $display("FAIL wr_sram_d_o got %h exp aaaa", sram_d_o); end
      n++;
      tick();
    end
    we = 1'b0; address = 16'h0000;
    #1;
    checks++; if (n !== 3) begin errors++; $display("FAIL wr_stall_cycles got %0d exp 3", n); end
    checks++; if (mem[15'h0080] !== 16'hAA00) begin errors++; $display("FAIL wr_sram_word got %h exp aa00", mem[15'h0080]); end
    checks++; if ({locked, dout} !== {1'b1, 8'hC0}) begin errors++;
      $display("FAIL wr_miss_buf_kept got %b/%h exp 1/c0", locked, dout); end
  endtask

  task automatic test_write_through();
    int n;
    preload(15'h0080, 16'h1234);
    address = 16'h0100;
    #1;
    n = 0;
    while (!locked && n < 20) begin n++; tick(); end
    checks++; if (dout !== 8'h34) begin errors++; $display("FAIL wt_fill_dout got %h exp 34", dout); end
    address = 16'h0101; din = 8'h55; we = 1'b1;
    tick();
    n = 0;
    while (!locked && n < 20) begin n++; tick(); end
    we = 1'b0;
    #1;
    checks++; if ({locked, dout} !== {1'b1, 8'h55}) begin errors++;
      $display("FAIL wt_hi_readback got %b/%h exp 1/55", locked, dout); end
    address = 16'h0100;
    #1;
    checks++; if ({locked, dout} !== {1'b1, 8'h34}) begin errors++;
      $display("FAIL wt_lo_readback got %b/%h exp 1/34", locked, dout); end
    checks++; if (mem[15'h0080] !== 16'h5534) begin errors++; $display("FAIL wt_sram_word got %h exp 5534", mem[15'h0080]); end
  endtask

  task automatic test_back_to_back();
    int acc, nw;
    logic [1:0]  lanes [0:7];
    logic [14:0] la [0:7];
    for (int i = 0; i < 8; i++) begin lanes[i] = 2'b11; la[i] = 15'h0; end
    acc = 0; nw = 0;
    address = 16'h2000; din = 8'hEF; we = 1'b1;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (!sram_we_n) begin
        if (nw < 8) begin lanes[nw] = {sram_ub_n, sram_lb_n}; la[nw] = sram_a; end
        nw++;
      end
      if (locked && we) begin
        acc++;
        tick();
        if (acc == 1) begin
          address = 16'h2001; din = 8'hBE;
        end else begin
          we = 1'b0; address = 16'h0100;
        end
      end else if (locked) begin
        break;
      end else begin
        tick();
      end
    end
    checks++; if (acc !== 2) begin errors++; $display("FAIL b2b_accepted got %0d exp 2", acc); end
    checks++; if (nw !== 6) begin errors++; $display("FAIL b2b_we_cycles got %0d exp 6", nw); end
    checks++; if (lanes[0] !== 2'b10) begin errors++; $display("FAIL b2b_first_lane got %b exp 10", lanes[0]); end
    checks++; if (lanes[3] !== 2'b01) begin errors++; $display("FAIL b2b_second_lane got %b exp 01", lanes[3]); end
    checks++; if ({la[0], la[3]} !== {15'h1000, 15'h1000}) begin errors++;
      $display("FAIL b2b_sram_a got %h/%h exp 1000/1000", la[0], la[3]); end
    checks++; if (mem[15'h1000] !== 16'hBEEF) begin errors++; $display("FAIL b2b_sram_word got %h exp beef", mem[15'h1000]); end
    checks++; if ({locked, dout} !== {1'b1, 8'h34}) begin errors++;
      $display("FAIL b2b_buf_kept got %b/%h exp 1/34", locked, dout); end
  endtask

  task automatic test_reset_mid_read();
    int n;
    preload(15'h0000, 16'h7E5A);
    address = 16'h0000;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL abort_miss_locked got %b exp 0", locked); end
    tick();
    tick();
    checks++; if (sram_oe_n !== 1'b0) begin errors++; $display("FAIL abort_in_read got %b exp 0", sram_oe_n); end
    reset_n = 1'b0;
    #1;
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL abort_locked_in_reset got %b exp 1", locked); end
    tick();
    checks++; if ({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_d_oe} !== 5'b11110) begin errors++;
      $display("FAIL abort_strobes got %b exp 11110", {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_d_oe}); end
    checks++; if ({locked, dout} !== {1'b1, 8'h00}) begin errors++;
      $display("FAIL abort_buf_cleared got %b/%h exp 1/00", locked, dout); end
    reset_n = 1'b1;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL abort_refetch_miss got %b exp 0", locked); end
    n = 0;
    while (!locked && n < 20) begin n++; tick(); end
    checks++; if (n !== 4) begin errors++; $display("FAIL abort_refetch_cycles got %0d exp 4", n); end
    checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL abort_refetch_dout got %h exp 5a", dout); end
  endtask

  task automatic test_wait0();
    int n;
    address_w0 = 16'hFFFF; reset_n_w0 = 1'b1;
    #1;
    n = 0;
    while (!locked_w0 && n < 20) begin
      if (n > 0) begin
        checks++; if ({sram_a_w0, sram_oe_n_w0, sram_ub_n_w0, sram_lb_n_w0} !== {15'h7FFF, 3'b000}) begin errors++;
          $display("FAIL w0_read_pins got %h/%b exp 7fff/000", sram_a_w0, {sram_oe_n_w0, sram_ub_n_w0, sram_lb_n_w0}); end
      end
      n++;
      tick();
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL w0_stall_cycles got %0d exp 2", n); end
    checks++; if (dout_w0 !== 8'h99) begin errors++; $display("FAIL w0_dout_hi got %h exp 99", dout_w0); end
    checks++; if ({sram_we_n_w0, sram_d_oe_w0, sram_d_o_w0} !== {2'b10, 16'h0000}) begin errors++;
      $display("FAIL w0_no_write got %b/%h exp 10/0000", {sram_we_n_w0, sram_d_oe_w0}, sram_d_o_w0); end
    address_w0 = 16'hFFFE;
    #1;
    checks++; if ({locked_w0, dout_w0} !== {1'b1, 8'h00}) begin errors++;
      $display("FAIL w0_lo_hit got %b/%h exp 1/00", locked_w0, dout_w0); end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write();
    test_write_through();
    test_back_to_back();
    test_reset_mid_read();
    test_wait0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core_mem_bridge.md
Name: core_mem_bridge

Overview:
- Responder end of the CPU core's byte bus: `address`, `we`, `out` and the `locked` stall input.
- Serves byte reads and writes from a 16-bit-wide asynchronous SRAM that needs wait states.
- Keeps a one-word read buffer and stalls the core (drops `locked`) during external reads and writes.
- Sits between the core and the board SRAM pins; replaces the single-cycle on-chip RAM.

Parameters:
- WAIT, 2: extra SRAM access cycles per read or write, range 0..15; every access lasts WAIT+1 cycles.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset_n  in  1  synchronous, active-low reset.
- address  in  16  byte address from core (combinational on core side).
- we  in  1  core write strobe.
- din  in  8  write byte from core (core `out`).
- dout  out  8  read byte to core (core `in`).
- locked  out  1  core clock-enable; 0 = core stalled.
- sram_a  out  15  SRAM word address.
- sram_d_i  in  16  SRAM read data.
- sram_d_o  out  16  SRAM write data.
- sram_d_oe  out  1  drive enable for the data pads.
- sram_oe_n  out  1  SRAM output enable, active low.
- sram_we_n  out  1  SRAM write enable, active low.
- sram_ub_n  out  1  SRAM upper byte lane enable, active low.
- sram_lb_n  out  1  SRAM lower byte lane enable, active low.

Behaviour:
- One clock; reset is synchronous and active-low: `clock`, `reset_n`.

Reset and state:
- Reset while reset_n=0 at posedge: state=IDLE, valid=0, tag=0, buf=0, cnt=0.
- Reset outputs: sram_oe_n=1, sram_we_n=1, sram_ub_n=1, sram_lb_n=1, sram_d_oe=0, sram_a=0, sram_d_o=0.
- `locked` is combinational and forced to 1 while reset_n=0, so the core samples its own reset.
- A reset mid-access aborts it: the SRAM strobes release on that edge and no buffer update occurs.
- Registers: state {IDLE, READ, WRITE}; cnt[3:0]; tag[14:0]; valid; buf[15:0]; waddr[15:0]; wdata[7:0].
- hit = valid && address[15:1]==tag.
- dout = address[0] ? buf[15:8] : buf[7:0], always combinational; only meaningful when locked=1.

locked (combinational):
- IDLE: locked = we | hit.
- READ and WRITE: locked = 0.

IDLE:
- If we=1: the core advances on this edge, so the write is accepted here.
  - Latch waddr=address, wdata=din; cnt=WAIT; go to WRITE.
  - If hit, update the addressed buf byte on the same edge (write-through).
- Else if miss: latch sram_a=address[15:1]; cnt=WAIT; sram_oe_n=0; go to READ.
- Else (hit, no write): stay in IDLE; the read completes with zero wait.

READ:
- Hold sram_oe_n=0 with both lane enables low.
- cnt≠0: decrement cnt.
- cnt==0: buf=sram_d_i, tag=sram_a, valid=1; release strobes; go to IDLE.
- `locked` stays low for WAIT+2 cycles per miss: the detect cycle plus WAIT+1 READ cycles. The next IDLE cycle hits.

WRITE:
- sram_a=waddr[15:1]; sram_d_o={wdata,wdata}; sram_d_oe=1; sram_we_n=0.
- Lane enables: ub_n=~waddr[0], lb_n=waddr[0].
- Held for WAIT+1 cycles, then strobes release and state returns to IDLE.
- `we` is ignored outside IDLE. A core that is stalled holds `we`, but the write was already consumed at the capture edge.
- A `we` seen back in IDLE is the next write, e.g. the high byte of a 16-bit store.

Boundaries:
- Address 0xFFFF maps to word 0x7FFF, upper lane.
- A 16-bit store to an odd address spans two words as two independent byte writes.
- A write while valid=0, or to a non-matching word, leaves buf, tag and valid unchanged.
- A write to the high byte of the buffered word followed by a read of it returns the new value with no stall.
- sram_d_oe is never 1 while sram_oe_n=0.

Test Plan:
- Reset, then address=0x0000 with SRAM word 0=0x31C0 -> locked low 4 cycles (WAIT=2), then dout=0xC0; address=0x0001 -> dout=0x31 with locked=1, no stall.
- we=1, address=0x0101, din=0xAA -> locked high on capture edge, then low 3 cycles; sram_a=0x080, sram_we_n=0 for 3 cycles, ub_n=0, lb_n=1, sram_d_o=0xAAAA.
- Buffer holds word 0x0080=0x1234; write 0x55 to 0x0101 -> read 0x0101 returns 0x55 immediately, read 0x0100 returns 0x34.
- Back-to-back 16-bit store of 0xBEEF to 0x2000 (low byte then high byte) -> two WRITE sequences, lanes lb then ub; SRAM word 0x1000=0xBEEF; core sees exactly two accepted writes.
- Assert reset_n=0 in the second READ cycle -> next edge strobes released, valid=0, locked=1 throughout reset; after release a read of 0x0000 re-fetches.
- WAIT=0 and address=0xFFFF with SRAM word 0x7FFF=0x9900 -> locked low exactly 2 cycles, dout=0x99.
